stopwatch_mode_ctrl: RTL

//  Converts raw board inputs (pause/clear buttons, adjust/select switches) into the

---
 rtl/stopwatch_mode_ctrl_pkg.sv | 25 ++
 rtl/stopwatch_mode_ctrl_input_debouncer.sv | 40 ++++
 rtl/stopwatch_mode_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/stopwatch_mode_ctrl_pkg.sv
// Shared mode encoding and defaults for the stopwatch mode controller and display.
package stopwatch_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_ADJ_SEC = 2'd2,
    ST_ADJ_MIN = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_CNT_W           = 20;

  localparam int NUM_IN   = 4;
  localparam int IN_PAUSE = 0;
  localparam int IN_CLEAR = 1;
  localparam int IN_ADJ   = 2;
  localparam int IN_SEL   = 3;

  // Bit order: [0] regular, [1] pause, [2] adjust seconds, [3] adjust minutes.
  function automatic logic [3:0] mode_onehot(state_e s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/stopwatch_mode_ctrl_input_debouncer.sv
// Two-flop synchroniser followed by a hold-time debouncer for one raw board input.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, stable_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      // Any return to the stable level restarts the hold count.
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Board-input front end for the stopwatch: debounces buttons/switches and drives one-hot mode plus clear.
module stopwatch_mode_ctrl
  import stopwatch_mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_pause,
  input  logic btn_clear,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic regular_mode,
  output logic adjust_seconds_mode,
  output logic adjust_minutes_mode,
  output logic pause_mode,
  output logic counter_clear
);

  logic [NUM_IN-1:0] raw, deb;

  assign raw = {sw_sel, sw_adj, btn_clear, btn_pause};

  input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb [NUM_IN-1:0] (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (raw),
    .stable_o(deb)
  );

  logic       pause_prev_q, latch_q, latch_d, press;
  logic       clr_q, counter_clear_q;
  logic [3:0] mode_q;
  state_e     state_q, state_d;

  // The FSM looks at the next latch value so a pause press reaches the
  // outputs with the same latency as a switch change.
  always_comb begin
    press   = deb[IN_PAUSE] & ~pause_prev_q;
    latch_d = latch_q;
    if (deb[IN_CLEAR])
      latch_d = 1'b0;
    else if (press && !deb[IN_ADJ])
      latch_d = ~latch_q;

    state_d = latch_d ? ST_PAUSED : ST_RUN;
    if (deb[IN_ADJ])
      state_d = deb[IN_SEL] ? ST_ADJ_SEC : ST_ADJ_MIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_prev_q    <= 1'b0;
      latch_q         <= 1'b0;
      state_q         <= ST_RUN;
      mode_q          <= mode_onehot(ST_RUN);
      clr_q           <= 1'b0;
      counter_clear_q <= 1'b0;
    end else begin
      pause_prev_q    <= deb[IN_PAUSE];
      latch_q         <= latch_d;
      state_q         <= state_d;
      mode_q          <= mode_onehot(state_q);
      // Two stages keep clear aligned with the mode outputs.
      clr_q           <= deb[IN_CLEAR];
      counter_clear_q <= clr_q;
    end
  end

  assign regular_mode        = mode_q[0];
  assign pause_mode          = mode_q[1];
  assign adjust_seconds_mode = mode_q[2];
  assign adjust_minutes_mode = mode_q[3];
  assign counter_clear       = counter_clear_q;

endmodule
